// File: rtl/adiabatic_clk_seq.sv
// rtl/adiabatic_clk_seq.sv - four-phase trapezoidal power-clock sequencer for two-stage adiabatic cells
module adiabatic_clk_seq #(
  parameter int STEP_CYCLES = 4,
  parameter int LVL_W       = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             clkpos,
  output logic             clkneg,
  output logic             clkpos2,
  output logic             clkneg2,
  output logic [LVL_W-1:0] lvl1,
  output logic [LVL_W-1:0] lvl2,
  output logic             eval_valid,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

  // Stage encoding shared by both phases
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_FALL = 2'd3;

  typedef enum logic {
    MODE_OFF = 1'b0,
    MODE_RUN = 1'b1
  } mode_t;

  mode_t             mode, mode_nxt;
  logic [1:0]        idx, idx_nxt;
  logic [STEP_W-1:0] step, step_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  // Decoded boundaries of the registered state
  logic step_end;
  logic eval_now;
  logic [1:0] st1;
  logic [1:0] st2;

  assign step_end = (step == STEP_LAST);
  assign eval_now = (mode == MODE_RUN) && (idx == ST_FALL) && step_end;

  // Phase 2 trails phase 1 by one stage: (idx + 3) mod 4 is idx - 1 in two bits
  assign st1 = (mode == MODE_RUN) ? idx : ST_IDLE;
  assign st2 = (mode == MODE_RUN) ? (idx - 2'd1) : ST_IDLE;

  // Ramp level for a stage at a given step within that stage
  function automatic logic [LVL_W-1:0] level_of(input logic [1:0] st, input logic [STEP_W-1:0] k);
    logic [LVL_W-1:0] kw;
    kw = LVL_W'(k);
    case (st)
      ST_RISE: level_of = kw + LVL_W'(1);
      ST_HOLD: level_of = LVL_W'(STEP_CYCLES);
      ST_FALL: level_of = LVL_W'(STEP_CYCLES - 1) - kw;
      default: level_of = '0;
    endcase
  endfunction

  // State register: mode, stage index, step within stage, evaluate counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= MODE_OFF;
      idx  <= ST_IDLE;
      step <= '0;
      cnt  <= '0;
    end else begin
      mode <= mode_nxt;
      idx  <= idx_nxt;
      step <= step_nxt;
      cnt  <= cnt_nxt;
    end
  end

  // Next state: run is only looked at from OFF or at the end of the IDLE stage,
  // the one point where both phases sit at level 0
  always_comb begin
    mode_nxt = mode;
    idx_nxt  = idx;
    step_nxt = step;
    cnt_nxt  = cnt;

    case (mode)
      MODE_OFF: begin
        if (run) begin
          mode_nxt = MODE_RUN;
          idx_nxt  = ST_RISE;
          step_nxt = '0;
        end
      end
      MODE_RUN: begin
        if (step_end) begin
          step_nxt = '0;
          if (idx == ST_IDLE) begin
            if (run) begin
              idx_nxt = ST_RISE;
            end else begin
              mode_nxt = MODE_OFF;
              idx_nxt  = ST_IDLE;
            end
          end else begin
            idx_nxt = idx + 2'd1;
          end
        end else begin
          step_nxt = step + STEP_W'(1);
        end
      end
      default: begin
        mode_nxt = MODE_OFF;
        idx_nxt  = ST_IDLE;
        step_nxt = '0;
      end
    endcase

    if (eval_now) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Moore outputs decoded from the registered state only
  always_comb begin
    clkpos     = (st1 == ST_HOLD);
    clkneg     = ~(st1 == ST_HOLD);
    clkpos2    = (st2 == ST_HOLD);
    clkneg2    = ~(st2 == ST_HOLD);
    lvl1       = level_of(st1, step);
    lvl2       = level_of(st2, step);
    eval_valid = eval_now;
    busy       = (mode != MODE_OFF);
    cycle_cnt  = cnt;
  end

endmodule

// File: tb/tb_adiabatic_clk_seq.sv
// tb/tb_adiabatic_clk_seq.sv - scoreboard bench for adiabatic_clk_seq
module tb_adiabatic_clk_seq;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       clkpos, clkneg, clkpos2, clkneg2;
  logic [2:0] lvl1, lvl2;
  logic       eval_valid, busy;
  logic [7:0] cycle_cnt;

  logic       b_clkpos, b_clkneg, b_clkpos2, b_clkneg2;
  logic [2:0] b_lvl1, b_lvl2;
  logic       b_eval_valid, b_busy;
  logic [1:0] b_cycle_cnt;

  int tests;
  int failed;

  adiabatic_clk_seq #(.STEP_CYCLES(4), .LVL_W(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .clkpos(clkpos), .clkneg(clkneg), .clkpos2(clkpos2), .clkneg2(clkneg2),
    .lvl1(lvl1), .lvl2(lvl2), .eval_valid(eval_valid), .busy(busy),
    .cycle_cnt(cycle_cnt)
  );

  adiabatic_clk_seq #(.STEP_CYCLES(4), .LVL_W(3), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .run(run),
    .clkpos(b_clkpos), .clkneg(b_clkneg), .clkpos2(b_clkpos2), .clkneg2(b_clkneg2),
    .lvl1(b_lvl1), .lvl2(b_lvl2), .eval_valid(b_eval_valid), .busy(b_busy),
    .cycle_cnt(b_cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       on;
    logic [3:0] pos;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;

  exp_t exp_q[$];

  // Model: position within the 16-cycle period, pos 0 = first RISE cycle
  logic       m_on;
  logic [3:0] m_pos;
  logic [7:0] m_cnt;
  logic [1:0] m_cnt2;

  function automatic logic [2:0] tab_lvl(input int p);
    case (p)
      0: return 3'd1;  1: return 3'd2;  2: return 3'd3;  3: return 3'd4;
      4, 5, 6, 7: return 3'd4;
      8: return 3'd3;  9: return 3'd2;  10: return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  task automatic push_exp();
    exp_t e;
    e.on = m_on; e.pos = m_pos; e.cnt = m_cnt; e.cnt2 = m_cnt2;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_on = 1'b0; m_pos = 4'd0; m_cnt = 8'd0; m_cnt2 = 2'd0;
    exp_q.delete();
  endtask

  // Compare the DUT against the oldest expectation, then drive run for the next edge
  task automatic tick(input logic r);
    exp_t e;
    logic [2:0] el1, el2;
    logic ecp, ecp2, eev;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      tests++; failed++;
      $display("FAIL scoreboard_empty act=0 req=1");
    end else begin
      e = exp_q.pop_front();
      el1  = e.on ? tab_lvl(int'(e.pos)) : 3'd0;
      el2  = e.on ? tab_lvl((int'(e.pos) + 12) % 16) : 3'd0;
      ecp  = e.on && (e.pos >= 4'd4) && (e.pos <= 4'd7);
      ecp2 = e.on && (e.pos >= 4'd8) && (e.pos <= 4'd11);
      eev  = e.on && (e.pos == 4'd11);
      tests++; if (lvl1 !== el1) begin failed++; $display("FAIL lvl1 pos=%0d act=%0d req=%0d", e.pos, lvl1, el1); end
      tests++; if (lvl2 !== el2) begin failed++; $display("FAIL lvl2 pos=%0d act=%0d req=%0d", e.pos, lvl2, el2); end
      tests++; if (clkpos !== ecp) begin failed++; $display("FAIL clkpos pos=%0d act=%b req=%b", e.pos, clkpos, ecp); end
      tests++; if (clkneg !== ~ecp) begin failed++; $display("FAIL clkneg pos=%0d act=%b req=%b", e.pos, clkneg, ~ecp); end
      tests++; if (clkpos2 !== ecp2) begin failed++; $display("FAIL clkpos2 pos=%0d act=%b req=%b", e.pos, clkpos2, ecp2); end
      tests++; if (clkneg2 !== ~ecp2) begin failed++; $display("FAIL clkneg2 pos=%0d act=%b req=%b", e.pos, clkneg2, ~ecp2); end
      tests++; if (eval_valid !== eev) begin failed++; $display("FAIL eval_valid pos=%0d act=%b req=%b", e.pos, eval_valid, eev); end
      tests++; if (busy !== e.on) begin failed++; $display("FAIL busy pos=%0d act=%b req=%b", e.pos, busy, e.on); end
      tests++; if (cycle_cnt !== e.cnt) begin failed++; $display("FAIL cycle_cnt act=%0d req=%0d", cycle_cnt, e.cnt); end
      tests++; if (b_cycle_cnt !== e.cnt2) begin failed++; $display("FAIL cycle_cnt_w2 act=%0d req=%0d", b_cycle_cnt, e.cnt2); end
      tests++; if ((b_clkneg !== ~b_clkpos) || (b_clkneg2 !== ~b_clkpos2)) begin
        failed++; $display("FAIL complement_w2 act=%b%b%b%b req=complementary", b_clkpos, b_clkneg, b_clkpos2, b_clkneg2);
      end
    end
    run = r;
    if (!m_on) begin
      if (r) begin m_on = 1'b1; m_pos = 4'd0; end
    end else begin
      if (m_pos == 4'd11) begin m_cnt = m_cnt + 8'd1; m_cnt2 = m_cnt2 + 2'd1; end
      if (m_pos == 4'd15) begin
        if (r) m_pos = 4'd0; else m_on = 1'b0;
      end else begin
        m_pos = m_pos + 4'd1;
      end
    end
    push_exp();
  endtask

  task automatic do_reset();
    run = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_exp();
  endtask

  task automatic test_reset();
    run = 1'b0;
    rst_n = 1'b0;
    #1;
    tests++; if ({busy, clkpos, clkneg, clkpos2, clkneg2} !== 5'b00101) begin
      failed++; $display("FAIL reset_ctrl act=%b req=00101", {busy, clkpos, clkneg, clkpos2, clkneg2});
    end
    tests++; if ({lvl1, lvl2, eval_valid, cycle_cnt} !== 15'd0) begin
      failed++; $display("FAIL reset_vals act=%0d/%0d/%b/%0d req=0", lvl1, lvl2, eval_valid, cycle_cnt);
    end
    do_reset();
    repeat (3) tick(1'b0);
  endtask

  task automatic test_start();
    do_reset();
    repeat (40) tick(1'b1);
  endtask

  task automatic test_eval();
    int pulses;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1'b1);
      if (eval_valid === 1'b1) pulses++;
    end
    tests++; if (pulses != 3) begin failed++; $display("FAIL eval_pulse_count act=%0d req=3", pulses); end
  endtask

  task automatic test_graceful_stop();
    do_reset();
    tick(1'b1);
    repeat (5) tick(1'b1);
    repeat (20) tick(1'b0);
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL stop_busy act=%b req=0", busy); end
  endtask

  task automatic test_glitch();
    do_reset();
    tick(1'b1);
    repeat (6) tick(1'b1);
    repeat (4) tick(1'b0);
    repeat (30) tick(1'b1);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    do_reset();
    tick(1'b1);
    repeat (9) tick(1'b1);
    @(negedge clk);
    e = exp_q.pop_front();
    tests++; if (lvl1 !== 3'd2) begin failed++; $display("FAIL mid_lvl1 pos=%0d act=%0d req=2", e.pos, lvl1); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({lvl1, lvl2} !== 6'd0) begin failed++; $display("FAIL mid_rst_lvl act=%0d/%0d req=0/0", lvl1, lvl2); end
    tests++; if ({clkneg, clkneg2, busy, cycle_cnt} !== 11'b11_0_00000000) begin
      failed++; $display("FAIL mid_rst_ctrl act=%b%b%b/%0d req=110/0", clkneg, clkneg2, busy, cycle_cnt);
    end
    run = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    push_exp();
    repeat (2) tick(1'b0);
  endtask

  task automatic test_wrap();
    do_reset();
    tick(1'b1);
    repeat (16 * 5 + 2) tick(1'b1);
    tests++; if (b_cycle_cnt !== 2'd1) begin failed++; $display("FAIL wrap_final act=%0d req=1", b_cycle_cnt); end
    tests++; if (cycle_cnt !== 8'd5) begin failed++; $display("FAIL wrap_wide act=%0d req=5", cycle_cnt); end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    run = 1'b0;
    rst_n = 1'b1;
    model_reset();
    test_reset();
    test_start();
    test_eval();
    test_graceful_stop();
    test_glitch();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
